asi_arb: RTL and testbench



---
 rtl/asi_pkg.sv | 25 ++
 rtl/asi_arb.sv | 133 +++++++++++++
 tb/tb_asi_arb.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/asi_pkg.sv
// Shared ASI types: arbiter state encoding, arbitration modes and side labels.
package asi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        R_GNT,
        R_DRAIN,
        W_GNT,
        W_DRAIN
    } ARB_STATE;

    typedef enum logic {
        R = 1'b0,
        W = 1'b1
    } ARB_SIDE;

    localparam int ARB_WPRI = 0;
    localparam int ARB_RPRI = 1;
    localparam int ARB_RR   = 2;

    function automatic ARB_SIDE arb_other(input ARB_SIDE s);
        return (s == R) ? W : R;
    endfunction

endpackage

// File: rtl/asi_arb.sv
// Read/write arbiter for the shared single-port user memory: burst-atomic grants,
// limited to QUANTUM bursts per grant, with a sticky protocol-violation flag.
module asi_arb
    import asi_pkg::*;
#(
    parameter int ARB_MODE = ARB_WPRI,
    parameter int QUANTUM  = 4,
    parameter int QW       = (QUANTUM > 0) ? $clog2(QUANTUM + 1) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic r_req,
    input  logic r_busy,
    output logic r_granted,
    input  logic w_req,
    input  logic w_busy,
    output logic w_granted,
    output logic arb_idle,
    output logic arb_err
);

    localparam int CW = (QW < 1) ? 1 : QW;

    ARB_STATE        state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            qexp_q, qexp_d;
    ARB_SIDE         last_q, last_d;
    logic            err_q, err_d;

    ARB_SIDE         winner;
    logic            r_acc, w_acc;
    logic            r_side, w_side;
    logic [CW-1:0]   cnt_inc;
    logic            q_last;

    // Outputs decode the state register only.
    assign r_granted = (state_q == R_GNT);
    assign w_granted = (state_q == W_GNT);
    assign arb_idle  = (state_q == IDLE);
    assign arb_err   = err_q;

    assign r_acc   = r_req & r_granted;
    assign w_acc   = w_req & w_granted;
    assign r_side  = (state_q == R_GNT) || (state_q == R_DRAIN);
    assign w_side  = (state_q == W_GNT) || (state_q == W_DRAIN);
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
    assign q_last  = (QUANTUM != 0) && (int'(cnt_q) == QUANTUM - 1);

    // An expired quantum forces a hand-over regardless of the configured mode.
    always_comb begin
        winner = W;
        if (r_req && !w_req) begin
            winner = R;
        end else if (w_req && !r_req) begin
            winner = W;
        end else if (qexp_q) begin
            winner = arb_other(last_q);
        end else begin
            case (ARB_MODE)
                ARB_RPRI: winner = R;
                ARB_RR:   winner = arb_other(last_q);
                default:  winner = W;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qexp_d  = qexp_q;
        last_d  = last_q;
        err_d   = err_q | (r_busy & w_busy) | (r_busy & ~r_side) | (w_busy & ~w_side);

        case (state_q)
            IDLE: begin
                if (r_req || w_req) begin
                    cnt_d   = '0;
                    qexp_d  = 1'b0;
                    state_d = (winner == R) ? R_GNT : W_GNT;
                end
            end
            R_GNT: begin
                if (r_acc) begin
                    last_d = R;
                    cnt_d  = cnt_inc;
                    if (q_last) begin
                        state_d = R_DRAIN;
                        qexp_d  = 1'b1;
                    end
                end else if (!r_req && !r_busy) begin
                    state_d = IDLE;
                end
            end
            R_DRAIN: begin
                if (!r_busy) state_d = IDLE;
            end
            W_GNT: begin
                if (w_acc) begin
                    last_d = W;
                    cnt_d  = cnt_inc;
                    if (q_last) begin
                        state_d = W_DRAIN;
                        qexp_d  = 1'b1;
                    end
                end else if (!w_req && !w_busy) begin
                    state_d = IDLE;
                end
            end
            W_DRAIN: begin
                if (!w_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Last side starts as W so that round-robin serves R first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            qexp_q  <= 1'b0;
            last_q  <= W;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qexp_q  <= qexp_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_asi_arb.sv
// Bench for asi_arb: three configurations driven by simple engine models and
// compared each cycle against an owner/turn reference model.
module tb_asi_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] r_req, r_busy, w_req, w_busy;
    logic [2:0] r_granted, w_granted, arb_idle, arb_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Engine models: pending bursts, remaining busy cycles, accept this cycle.
    int rpend[3], wpend[3], rrem[3], wrem[3], blen[3], tot_acc[3];
    bit racc[3], wacc[3];
    bit rnd_len = 0, rnd_arr = 0, mdl_en = 0;

    // Reference model: owner 0 none / 1 R / 2 W, draining flag, bursts this turn.
    int m_owner[3], m_drain[3], m_turn[3], m_exp[3], m_last[3], m_err[3];

    int log_i = -1;
    int acc_log[$], rise_side[$], rise_cyc[$], gap_log[$], rs[$], rl[$];
    int last_busy;
    bit prev_rg, prev_wg;
    int drop_c, wrise, wcount, nrise;

    always #5 clk = ~clk;

    asi_arb #(.ARB_MODE(0), .QUANTUM(4)) u_wpri (
        .clk(clk), .rst_n(rst_n),
        .r_req(r_req[0]), .r_busy(r_busy[0]), .r_granted(r_granted[0]),
        .w_req(w_req[0]), .w_busy(w_busy[0]), .w_granted(w_granted[0]),
        .arb_idle(arb_idle[0]), .arb_err(arb_err[0]));

    asi_arb #(.ARB_MODE(2), .QUANTUM(4)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .r_req(r_req[1]), .r_busy(r_busy[1]), .r_granted(r_granted[1]),
        .w_req(w_req[1]), .w_busy(w_busy[1]), .w_granted(w_granted[1]),
        .arb_idle(arb_idle[1]), .arb_err(arb_err[1]));

    asi_arb #(.ARB_MODE(1), .QUANTUM(0)) u_q0 (
        .clk(clk), .rst_n(rst_n),
        .r_req(r_req[2]), .r_busy(r_busy[2]), .r_granted(r_granted[2]),
        .w_req(w_req[2]), .w_busy(w_busy[2]), .w_granted(w_granted[2]),
        .arb_idle(arb_idle[2]), .arb_err(arb_err[2]));

    function automatic int mode_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
    endfunction

    function automatic int quant_of(input int i);
        return (i == 2) ? 0 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset(input int i);
        m_owner[i] = 0; m_drain[i] = 0; m_turn[i] = 0;
        m_exp[i] = 0; m_last[i] = 2; m_err[i] = 0;
    endtask

    task automatic model_check(input int i);
        chk($sformatf("u%0d r_granted c%0d", i, cyc), r_granted[i], (m_owner[i] == 1 && m_drain[i] == 0));
        chk($sformatf("u%0d w_granted c%0d", i, cyc), w_granted[i], (m_owner[i] == 2 && m_drain[i] == 0));
        chk($sformatf("u%0d arb_idle c%0d", i, cyc), arb_idle[i], (m_owner[i] == 0));
        chk($sformatf("u%0d arb_err c%0d", i, cyc), arb_err[i], m_err[i]);
    endtask

    // Predicts who holds the port after the coming edge from this cycle's inputs.
    task automatic model_step(input int i);
        int  other, win, q;
        bit  rq, rb, wq, wb, sq, sb;
        rq = r_req[i]; rb = r_busy[i]; wq = w_req[i]; wb = w_busy[i];
        q = quant_of(i);
        if ((rb && wb) || (rb && m_owner[i] != 1) || (wb && m_owner[i] != 2)) m_err[i] = 1;
        other = (m_last[i] == 1) ? 2 : 1;
        if (m_owner[i] == 0) begin
            if (rq || wq) begin
                if (rq && !wq)      win = 1;
                else if (wq && !rq) win = 2;
                else if (m_exp[i] != 0) win = other;
                else if (mode_of(i) == 0) win = 2;
                else if (mode_of(i) == 1) win = 1;
                else win = other;
                m_owner[i] = win; m_drain[i] = 0; m_turn[i] = 0; m_exp[i] = 0;
            end
        end else begin
            sq = (m_owner[i] == 1) ? rq : wq;
            sb = (m_owner[i] == 1) ? rb : wb;
            if (m_drain[i] != 0) begin
                if (!sb) m_owner[i] = 0;
            end else if (sq) begin
                m_last[i] = m_owner[i];
                m_turn[i]++;
                if (q != 0 && m_turn[i] >= q) begin
                    m_drain[i] = 1; m_exp[i] = 1;
                end
            end else if (!sb) begin
                m_owner[i] = 0;
            end
        end
    endtask

    task automatic eng_update(input int i);
        if (racc[i]) begin
            rpend[i]--;
            rrem[i] = rnd_len ? int'($urandom_range(2, 0)) : blen[i] - 1;
        end else if (rrem[i] > 0) rrem[i]--;
        if (wacc[i]) begin
            wpend[i]--;
            wrem[i] = rnd_len ? int'($urandom_range(2, 0)) : blen[i] - 1;
        end else if (wrem[i] > 0) wrem[i]--;
        if (rnd_arr) begin
            if ($urandom_range(7, 0) == 0) rpend[i] += int'($urandom_range(3, 1));
            if ($urandom_range(7, 0) == 0) wpend[i] += int'($urandom_range(3, 1));
        end
    endtask

    task automatic eng_drive(input int i);
        r_req[i]  = (rpend[i] > 0) && (rrem[i] <= 1);
        racc[i]   = r_req[i] && r_granted[i];
        r_busy[i] = racc[i] || (rrem[i] > 0);
        w_req[i]  = (wpend[i] > 0) && (wrem[i] <= 1);
        wacc[i]   = w_req[i] && w_granted[i];
        w_busy[i] = wacc[i] || (wrem[i] > 0);
        if (racc[i] || wacc[i]) tot_acc[i]++;
    endtask

    task automatic log_cycle(input int i);
        if (r_granted[i] && !prev_rg) begin
            rise_side.push_back(1); rise_cyc.push_back(cyc);
            if (last_busy >= 0) gap_log.push_back(cyc - (last_busy + 1));
        end
        if (w_granted[i] && !prev_wg) begin
            rise_side.push_back(2); rise_cyc.push_back(cyc);
            if (last_busy >= 0) gap_log.push_back(cyc - (last_busy + 1));
        end
        prev_rg = r_granted[i];
        prev_wg = w_granted[i];
        if (r_busy[i] || w_busy[i]) last_busy = cyc;
        if (racc[i]) acc_log.push_back(1);
        if (wacc[i]) acc_log.push_back(2);
    endtask

    task automatic step_all();
        tick();
        for (int i = 0; i < 3; i++) begin
            if (mdl_en) model_check(i);
            eng_update(i);
            eng_drive(i);
            if (i == log_i) log_cycle(i);
            model_step(i);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        r_req = '0; r_busy = '0; w_req = '0; w_busy = '0;
        for (int i = 0; i < 3; i++) begin
            rpend[i] = 0; wpend[i] = 0; rrem[i] = 0; wrem[i] = 0;
            racc[i] = 0; wacc[i] = 0; blen[i] = 1; tot_acc[i] = 0;
            model_reset(i);
        end
        acc_log.delete(); rise_side.delete(); rise_cyc.delete(); gap_log.delete();
        last_busy = -1; prev_rg = 0; prev_wg = 0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        r_req = '0; r_busy = '0; w_req = '0; w_busy = '0;
        #12;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset u%0d r_granted", i), r_granted[i], 1'b0);
            chk($sformatf("reset u%0d w_granted", i), w_granted[i], 1'b0);
            chk($sformatf("reset u%0d arb_idle", i), arb_idle[i], 1'b1);
            chk($sformatf("reset u%0d arb_err", i), arb_err[i], 1'b0);
        end

        // Single read request at cycle 5, dropped mid-burst, released at cycle 9.
        do_reset();
        repeat (5) tick();
        chk("t1 idle c5", arb_idle[0], 1'b1);
        r_req[0] = 1'b1;
        tick();
        chk("t1 r_granted c6", r_granted[0], 1'b1);
        chk("t1 w_granted c6", w_granted[0], 1'b0);
        r_busy[0] = 1'b1;
        tick();
        chk("t1 r_granted c7", r_granted[0], 1'b1);
        r_req[0] = 1'b0;
        tick();
        chk("t1 held by busy c8", r_granted[0], 1'b1);
        chk("t1 w_granted c8", w_granted[0], 1'b0);
        r_busy[0] = 1'b0;
        tick();
        chk("t1 idle c9", arb_idle[0], 1'b1);
        chk("t1 r_granted c9", r_granted[0], 1'b0);
        chk("t1 arb_err c9", arb_err[0], 1'b0);

        // Write priority: W first, then the expired quantum hands over to R.
        do_reset();
        mdl_en = 1; log_i = 0;
        rpend[0] = 12; wpend[0] = 12;
        repeat (30) step_all();
        chk("t2 first grant side", (rise_side.size() > 0) ? rise_side[0] : -1, 2);
        chk("t2 second grant side", (rise_side.size() > 1) ? rise_side[1] : -1, 1);
        wcount = 0;
        foreach (acc_log[k]) begin
            if (acc_log[k] == 1) break;
            wcount++;
        end
        chk("t2 W accepts before R", wcount, 4);

        // Round-robin with 2-cycle bursts: alternating turns of 4, 2-cycle bubble.
        do_reset();
        log_i = 1; blen[1] = 2;
        rpend[1] = 16; wpend[1] = 16;
        repeat (90) step_all();
        rs.delete(); rl.delete();
        foreach (acc_log[k]) begin
            if (rs.size() > 0 && rs[rs.size() - 1] == acc_log[k]) rl[rl.size() - 1]++;
            else begin
                rs.push_back(acc_log[k]);
                rl.push_back(1);
            end
        end
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t3 turn%0d side", k), (rs.size() > k) ? rs[k] : -1, (k % 2 == 0) ? 1 : 2);
            chk($sformatf("t3 turn%0d accepts", k), (rl.size() > k) ? rl[k] : -1, 4);
        end
        for (int k = 0; k < 5; k++)
            chk($sformatf("t3 switch%0d gap", k), (gap_log.size() > k) ? gap_log[k] : -1, 2);

        // Unlimited quantum: read keeps the grant until it stops requesting.
        do_reset();
        log_i = 2;
        rpend[2] = 100000; wpend[2] = 5;
        repeat (40) step_all();
        wcount = 0;
        foreach (acc_log[k]) if (acc_log[k] == 2) wcount++;
        chk("t4 W accepts while R holds", wcount, 0);
        chk("t4 grant count while R holds", rise_side.size(), 1);
        chk("t4 R still granted", r_granted[2], 1'b1);
        chk("t4 R accepts", tot_acc[2], 39);
        rpend[2] = 0;
        drop_c = cyc + 1;
        nrise = rise_side.size();
        repeat (6) step_all();
        wrise = -1;
        for (int k = nrise; k < rise_side.size(); k++)
            if (rise_side[k] == 2 && wrise < 0) wrise = rise_cyc[k];
        chk("t4 W grant delay after R drop", wrise - drop_c, 2);

        // Protocol violation then asynchronous reset mid-burst.
        mdl_en = 0; log_i = -1;
        do_reset();
        tick();
        r_req[0] = 1'b1;
        tick();
        chk("t5 r_granted", r_granted[0], 1'b1);
        r_busy[0] = 1'b1;
        tick();
        chk("t5 err before", arb_err[0], 1'b0);
        r_req[0] = 1'b0;
        w_busy[0] = 1'b1;
        tick();
        chk("t5 err set", arb_err[0], 1'b1);
        w_busy[0] = 1'b0;
        repeat (2) tick();
        chk("t5 err sticky", arb_err[0], 1'b1);
        chk("t5 grant before reset", r_granted[0], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5 async r_granted", r_granted[0], 1'b0);
        chk("t5 async w_granted", w_granted[0], 1'b0);
        chk("t5 async arb_idle", arb_idle[0], 1'b1);
        chk("t5 async arb_err", arb_err[0], 1'b0);

        // Randomized traffic on all three configurations against the model.
        do_reset();
        mdl_en = 1; rnd_len = 1; rnd_arr = 1;
        repeat (1500) step_all();
        for (int i = 0; i < 3; i++)
            chk($sformatf("rand u%0d traffic flowed", i), (tot_acc[i] > 50), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
